// File: rtl/pakin_pkg.sv
// Shared types and helpers for the pakin packet-to-message reassembler.
`timescale 1ns/1ps
package pakin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ASM       = 2'd1,
        ST_FULL_WAIT = 2'd2
    } asm_state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
        return (inc && (v != ERR_CNT_MAX)) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/ns_msg_fifo.sv
// Message FIFO for packet receivers: W bits wide, DEPTH deep (power of two, >= 2).
// Head is read straight from the storage registers; full/empty use an extra pointer bit.
`timescale 1ns/1ps
module ns_msg_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A pop frees its slot before a same-cycle push is judged against full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/pakin.sv
// pakin: rebuilds {redun, data, addr} messages from indexed packets and queues them for output.
// Optional NS_PAKIN_REDUN_CHECK_EN drops messages whose redundancy field is inconsistent.
`timescale 1ns/1ps
module pakin
    import pakin_pkg::*;
#(
    parameter int PSZ     = 8,
    parameter int FSZ     = 2,
    parameter int ASZ     = 8,
    parameter int DSZ     = 8,
    parameter int RSZ     = 4,
    parameter int REQ_CKS = 2,
    parameter int ACK_CKS = 2,
    localparam int MSZ     = ASZ + DSZ + RSZ,
    localparam int TOT_PKS = MSZ / PSZ + 1,
    localparam int PIW     = (TOT_PKS > 1) ? $clog2(TOT_PKS) : 1
) (
    input  logic               i_clk,
    input  logic               reset,
    output logic               ready,
    input  logic [PIW+PSZ-1:0] rcv0_pakio,
    input  logic               rcv0_req,
    output logic               rcv0_ack,
    output logic [MSZ-1:0]     snd0_dat,
    output logic               snd0_req,
    input  logic               snd0_ack,
    output logic [7:0]         err_cnt
);

    localparam int RCW = $clog2(REQ_CKS + 1);
    localparam int ACW = $clog2(ACK_CKS + 1);

    logic           rg_rdy;
    logic           rcv0_rdy;
    logic           snd0_rdy;
    logic           req_db;
    logic           ack_db;
    logic [RCW-1:0] req_cnt;
    logic [RCW-1:0] req_st;
    logic [ACW-1:0] ack_cnt;
    logic [ACW-1:0] ack_st;

    asm_state_t     state;
    asm_state_t     state_n;
    logic [PIW-1:0] nxt;
    logic [PIW-1:0] nxt_n;
    logic           ack_n;
    logic           err_inc;
    logic           asm_we;
    logic [MSZ-1:0] asm_buf;
    logic [MSZ-1:0] asm_nxt;

    logic [PIW-1:0] pkt_idx;
    logic [PSZ-1:0] pkt_pay;
    logic [PIW-1:0] exp_idx;
    logic           idx_hit;
    logic           idx_start;
    logic           is_last;
    logic           redun_ok;

    logic           push;
    logic [MSZ-1:0] push_dat;
    logic           pop;
    logic [MSZ-1:0] fifo_head;
    logic           fifo_empty;
    logic           fifo_full;

    assign ready = rg_rdy && rcv0_rdy && snd0_rdy;

    // Debouncers: the filtered level follows the pin after CKS cycles of disagreement;
    // "settled" is declared once the pin has agreed with it for CKS consecutive cycles.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            rg_rdy   <= 1'b0;
            req_db   <= 1'b0;
            req_cnt  <= '0;
            req_st   <= '0;
            rcv0_rdy <= 1'b0;
            ack_db   <= 1'b0;
            ack_cnt  <= '0;
            ack_st   <= '0;
            snd0_rdy <= 1'b0;
        end else begin
            rg_rdy <= 1'b1;

            if (rcv0_req == req_db) req_cnt <= '0;
            else if (req_cnt == RCW'(REQ_CKS - 1)) begin
                req_db  <= rcv0_req;
                req_cnt <= '0;
            end else req_cnt <= req_cnt + 1'b1;

            if (!rcv0_rdy) begin
                if (rcv0_req != req_db) req_st <= '0;
                else if (req_st == RCW'(REQ_CKS - 1)) rcv0_rdy <= 1'b1;
                else req_st <= req_st + 1'b1;
            end

            if (snd0_ack == ack_db) ack_cnt <= '0;
            else if (ack_cnt == ACW'(ACK_CKS - 1)) begin
                ack_db  <= snd0_ack;
                ack_cnt <= '0;
            end else ack_cnt <= ack_cnt + 1'b1;

            if (!snd0_rdy) begin
                if (snd0_ack != ack_db) ack_st <= '0;
                else if (ack_st == ACW'(ACK_CKS - 1)) snd0_rdy <= 1'b1;
                else ack_st <= ack_st + 1'b1;
            end
        end
    end

`ifdef NS_PAKIN_REDUN_CHECK_EN
    function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] a,
                                                  input logic [DSZ-1:0] d);
        logic [MSZ-1:0] s;
        s = MSZ'(a) + MSZ'(d);
        return s[RSZ-1:0];
    endfunction

    assign redun_ok = (asm_nxt[ASZ+DSZ +: RSZ] == calc_redun(asm_nxt[ASZ-1:0], asm_nxt[ASZ +: DSZ]));
`else
    assign redun_ok = 1'b1;
`endif

    // Packet decode and the assembly image with the incoming payload merged in;
    // payload bits that land beyond MSZ in the last packet simply have no home.
    always_comb begin
        pkt_idx   = rcv0_pakio[PIW+PSZ-1:PSZ];
        pkt_pay   = rcv0_pakio[PSZ-1:0];
        exp_idx   = (state == ST_IDLE) ? '0 : nxt;
        idx_hit   = (pkt_idx == exp_idx);
        idx_start = (pkt_idx == '0);
        is_last   = (pkt_idx == PIW'(TOT_PKS - 1));
        asm_nxt   = asm_buf;
        for (int j = 0; j < MSZ; j++) begin
            if (PIW'(j / PSZ) == pkt_idx) asm_nxt[j] = pkt_pay[j % PSZ];
        end
    end

    assign pop      = snd0_req && ack_db;
    assign push_dat = (state == ST_FULL_WAIT) ? asm_buf : asm_nxt;

    always_comb begin
        state_n = state;
        nxt_n   = nxt;
        ack_n   = rcv0_ack;
        err_inc = 1'b0;
        push    = 1'b0;
        asm_we  = 1'b0;
        if (ready && req_db && !rcv0_ack) begin
            if (state == ST_FULL_WAIT) begin
                if (!fifo_full || pop) begin
                    push    = 1'b1;
                    ack_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end else if (!idx_hit && !idx_start) begin
                // Out-of-order packet: drop the partial message but keep the link moving.
                err_inc = 1'b1;
                ack_n   = 1'b1;
                nxt_n   = '0;
                state_n = ST_IDLE;
            end else begin
                err_inc = !idx_hit;
                asm_we  = 1'b1;
                if (is_last) begin
                    nxt_n = '0;
                    if (!redun_ok) begin
                        err_inc = 1'b1;
                        ack_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else if (!fifo_full || pop) begin
                        push    = 1'b1;
                        ack_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_FULL_WAIT;
                    end
                end else begin
                    ack_n   = 1'b1;
                    nxt_n   = pkt_idx + PIW'(1);
                    state_n = ST_ASM;
                end
            end
        end else if (!req_db && rcv0_ack) begin
            ack_n = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            nxt      <= '0;
            rcv0_ack <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_n;
            nxt      <= nxt_n;
            rcv0_ack <= ack_n;
            err_cnt  <= sat_inc8(err_cnt, err_inc);
        end
    end

    always_ff @(posedge i_clk) begin
        if (asm_we) asm_buf <= asm_nxt;
    end

    ns_msg_fifo #(
        .W     (MSZ),
        .DEPTH (FSZ)
    ) u_fifo (
        .i_clk    (i_clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Output channel: the head is latched when offered, so snd0_dat holds while snd0_req is up.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            snd0_req <= 1'b0;
            snd0_dat <= '0;
        end else if (pop) begin
            snd0_req <= 1'b0;
        end else if (ready && !snd0_req && !ack_db && !fifo_empty) begin
            snd0_req <= 1'b1;
            snd0_dat <= fifo_head;
        end
    end

endmodule

// File: doc/pakin.md
# pakin

Packet-to-message reassembler: the receive end of the packet link driven by `pakout`. It accepts fixed-size packets over a 4-phase req/ack channel and rebuilds full messages (address, data, redundancy). Completed messages are queued in a small FIFO and presented on a 4-phase message output channel toward the cell fabric.

## Interface
- `PSZ`, `NS_PACKET_SIZE`: payload bits per packet.
- `FSZ`, `NS_PACKOUT_FSZ`: message FIFO depth; power of two, ≥2.
- `ASZ`, `NS_ADDRESS_SIZE`: address field width.
- `DSZ`, `NS_DATA_SIZE`: data field width.
- `RSZ`, `NS_REDUN_SIZE`: redundancy field width.
- Derived: `MSZ = ASZ+DSZ+RSZ`, `TOT_PKS = MSZ/PSZ + 1`, `PIW = max(1, clog2(TOT_PKS))`.
- `i_clk`  in  1  clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `ready`  out  1  block initialised and both debouncers settled.
- `rcv0_pakio`  in  PIW+PSZ  packet: `[PIW+PSZ-1:PSZ]` = packet index, `[PSZ-1:0]` = payload.
- `rcv0_req`  in  1  packet request.
- `rcv0_ack`  out  1  packet acknowledge.
- `snd0_dat`  out  MSZ  message `{redun, data, addr}`, with addr in the LSBs.
- `snd0_req`  out  1  message request.
- `snd0_ack`  in  1  message acknowledge.
- `err_cnt`  out  8  saturating count of dropped messages.

## Operation
- `rcv0_req` is debounced with `NS_REQ_CKS`, and `snd0_ack` with `NS_ACK_CKS`. `ready = rg_rdy && rcv0_rdy && snd0_rdy`.
- Packet k carries message bits `[k*PSZ +: PSZ]`, for k = 0..TOT_PKS-1. In the last packet, bits beyond MSZ are ignored.
- Assembly state:
  - `IDLE`: expects index 0.
  - `ASM`: expects index `nxt`.
  - `FULL_WAIT`: the last packet is held, un-acked, until the FIFO has space.
- Packet accept:
  - Condition: `rcv0_req && !rcv0_ack` and the index equals the expected value.
  - Action: write the payload into the assembly register, raise `rcv0_ack`, increment `nxt`.
- Index mismatch:
  - The partial message is discarded, `err_cnt` increments, and the packet is still acked.
  - If the mismatched index is 0, it is accepted as the start of a new message.
- Last packet (index TOT_PKS-1):
  - FIFO not full: push the message, ack, return to `IDLE`.
  - FIFO full: go to `FULL_WAIT` with ack held low.
- `rcv0_ack` drops on the first cycle `!rcv0_req && rcv0_ack`.
- Output side:
  - Condition: FIFO non-empty, `!snd0_req`, `!snd0_ack`.
  - Action: drive the head onto `snd0_dat` and raise `snd0_req`.
  - On `snd0_ack`: drop `snd0_req` and pop the FIFO.
  - The next message is not offered until `snd0_ack` is low.
- `snd0_dat` is stable while `snd0_req` is high.

## Timing
- Reset values: `ready=0`, `rcv0_ack=0`, `snd0_req=0`, `snd0_dat=0`, `err_cnt=0`. FIFO empty, state `IDLE`.
- First clock after reset release: `rg_rdy` rises.
- Packet ack: `rcv0_ack` rises 1 cycle after the debounced req is seen.
- Message latency: `snd0_req` rises 2 cycles after the last-packet ack (push, then offer) when the FIFO was empty.
- Simultaneous push and pop with the FIFO full: the pop takes effect first, and the push is accepted the same cycle.
- Pointers wrap modulo FSZ. Full/empty is distinguished by an extra pointer bit.
- Reset mid-operation: the partial message and all queued messages are lost. An in-flight ack or req drops asynchronously.
- `err_cnt` saturates at 255.

## Configuration
- Macro: `NS_PAKIN_REDUN_CHECK_EN`.
- Defined: before push, check `redun == (addr + data)[RSZ-1:0]`. On mismatch the message is dropped, `err_cnt` increments, and the last packet is still acked.
- Undefined: redundancy is passed through unchecked, and only index errors count.

## Structure
- `hglobal.v` gets:
  - `NS_FULL_MSG_SZ`.
  - New macros `NS_DECLARE_PAKIN_CHNL` and `NS_DECLARE_OUT_MSG_CHNL`.
  - The redundancy function macro `NS_CALC_REDUN`.
  - Reuse of the existing debouncer and FIFO macros.
- One sub-module, `ns_msg_fifo` (MSZ wide, FSZ deep, registered head), shared with future receivers.

## Test plan
- ASZ=8, DSZ=8, RSZ=4, PSZ=8 (TOT_PKS=3). Send packets idx 0,1,2 for addr=0x12, data=0x34, red=0x6 → `snd0_dat=0x63412`, one `snd0_req` pulse, `err_cnt=0`.
- Send idx 0,2 → partial message dropped, `err_cnt=1`, no `snd0_req`. A following clean 0,1,2 message is delivered.
- Hold `snd0_ack` low, FSZ=2, send 3 messages → third last packet left un-acked (`FULL_WAIT`). Ack one output → third message accepted within 2 cycles.
- With `NS_PAKIN_REDUN_CHECK_EN`, red=0x0 for addr=0x12, data=0x34 → dropped, `err_cnt=1`. Without the macro → delivered.
- Assert `reset` after packet idx 1 → `rcv0_ack=0`, `snd0_req=0`, `ready=0` immediately. After release, a full message is delivered correctly.
- 300 bad-index packets → `err_cnt=255`, saturated.
